// File: rtl/controle_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving 7-segment decoders.
// Optional leading-zero blanking is enabled by defining SUPRIME_ZEROS_EN.
module controle_display #(
    parameter int unsigned LARGURA = 16,
    parameter int unsigned DIGITOS = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic [LARGURA-1:0]     valor,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   estouro,
    output logic [4*DIGITOS-1:0]   bcd_saida
);

    localparam int unsigned BW = 4 * DIGITOS;
    localparam int unsigned CW = $clog2(LARGURA + 1);

`ifdef SUPRIME_ZEROS_EN
    localparam logic [BW-1:0] BCD_RESET = {BW{1'b1}} << 4;
`else
    localparam logic [BW-1:0] BCD_RESET = '0;
`endif

    typedef enum logic [1:0] {StOcioso, StConverte, StFim} estado_t;

    estado_t            estado_q;
    logic [LARGURA-1:0] desloc_q;
    logic [BW-1:0]      rasc_q;
    logic [BW-1:0]      rasc_aj;
    logic [BW-1:0]      bcd_final;
    logic [CW-1:0]      cont_q;
    logic               ovf_q;

    assign ocupado = (estado_q != StOcioso);

    // Add-3 per digit, independent nibbles, applied before every shift.
    always_comb begin
        rasc_aj = rasc_q;
        for (int k = 0; k < int'(DIGITOS); k++) begin
            if (rasc_q[4*k +: 4] >= 4'd5) begin
                rasc_aj[4*k +: 4] = rasc_q[4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef SUPRIME_ZEROS_EN
    logic lider;

    // Blank every digit above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        bcd_final = rasc_q;
        lider     = 1'b1;
        for (int k = int'(DIGITOS) - 1; k >= 1; k--) begin
            if (lider && (rasc_q[4*k +: 4] == 4'd0)) begin
                bcd_final[4*k +: 4] = 4'hF;
            end else begin
                lider = 1'b0;
            end
        end
    end
`else
    always_comb begin
        bcd_final = rasc_q;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= StOcioso;
            pronto    <= 1'b0;
            estouro   <= 1'b0;
            bcd_saida <= BCD_RESET;
            desloc_q  <= '0;
            rasc_q    <= '0;
            cont_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pronto <= 1'b0;
            unique case (estado_q)
                StOcioso: begin
                    if (inicio) begin
                        desloc_q <= valor;
                        rasc_q   <= '0;
                        cont_q   <= CW'(LARGURA);
                        ovf_q    <= 1'b0;
                        estado_q <= StConverte;
                    end
                end
                StConverte: begin
                    {rasc_q, desloc_q} <= {rasc_aj[BW-2:0], desloc_q, 1'b0};
                    if (rasc_aj[BW-1]) begin
                        ovf_q <= 1'b1;
                    end
                    cont_q <= cont_q - CW'(1);
                    if (cont_q == CW'(1)) begin
                        estado_q <= StFim;
                    end
                end
                StFim: begin
                    bcd_saida <= ovf_q ? '1 : bcd_final;
                    estouro   <= ovf_q;
                    pronto    <= 1'b1;
                    estado_q  <= StOcioso;
                end
                default: estado_q <= StOcioso;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_display.sv
// Scoreboard bench for controle_display: a 5-digit and a 4-digit instance share clock and reset.
// Expected results follow SUPRIME_ZEROS_EN when it is defined.
module tb_controle_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicio, inicio4;
    logic [15:0] valor, valor4;
    logic        ocupado, pronto, estouro;
    logic        ocupado4, pronto4, estouro4;
    logic [19:0] bcd;
    logic [15:0] bcd4;

    typedef struct {
        logic [19:0] bcd;
        logic        est;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 0;

    controle_display #(.LARGURA(16), .DIGITOS(5)) dut (
        .clock(clock), .reset(reset), .inicio(inicio), .valor(valor),
        .ocupado(ocupado), .pronto(pronto), .estouro(estouro), .bcd_saida(bcd)
    );

    controle_display #(.LARGURA(16), .DIGITOS(4)) dut4 (
        .clock(clock), .reset(reset), .inicio(inicio4), .valor(valor4),
        .ocupado(ocupado4), .pronto(pronto4), .estouro(estouro4), .bcd_saida(bcd4)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [19:0] pick(input logic [19:0] plain, input logic [19:0] blanked);
`ifdef SUPRIME_ZEROS_EN
        return blanked;
`else
        return plain;
`endif
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Called #1 after an edge; the next edge is E0, result is visible 18 edges from now.
    task automatic go(input bit d4, input logic [15:0] v, input logic [19:0] e,
                      input bit eo, input bit push_it);
        exp_t x;
        x.bcd = e;
        x.est = eo;
        x.cyc = cyc + 18;
        if (d4) begin
            inicio4 = 1'b1;
            valor4  = v;
            if (push_it) q4.push_back(x);
        end else begin
            inicio = 1'b1;
            valor  = v;
            if (push_it) q0.push_back(x);
        end
        @(posedge clock); #1;
        inicio  = 1'b0;
        inicio4 = 1'b0;
        chk(d4 ? "ocupado4_after_accept" : "ocupado_after_accept", d4 ? ocupado4 : ocupado, 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin : mon0
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clock); #1;
            if (pronto) begin
                if (q0.size() == 0) begin
                    chk("unexpected_pronto", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("bcd_saida", bcd, e.bcd);
                    chk("estouro", estouro, e.est);
                    chk("ocupado_at_pronto", ocupado, 0);
                end
            end
        end
    end

    initial begin : mon4
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clock); #1;
            if (pronto4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_pronto4", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk("latency4", cyc, e.cyc);
                    chk("bcd_saida4", bcd4, e.bcd[15:0]);
                    chk("estouro4", estouro4, e.est);
                    chk("ocupado4_at_pronto", ocupado4, 0);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        inicio  = 1'b0;
        inicio4 = 1'b0;
        valor   = '0;
        valor4  = '0;
        wait_cycles(3);
        chk("reset_ocupado", ocupado, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_estouro", estouro, 0);
        chk("reset_bcd", bcd, pick(20'h00000, 20'hFFFF0));
        chk("reset_bcd4", bcd4, pick(20'h00000, 20'h0FFF0));
        reset  = 1'b0;
        mon_en = 1;
        wait_cycles(1);

        go(0, 16'd1234, pick(20'h01234, 20'hF1234), 0, 1);
        wait_cycles(20);

        // Back-to-back: new start accepted in the pronto cycle
        go(0, 16'd65535, pick(20'h65535, 20'h65535), 0, 1);
        wait_cycles(17);
        chk("pronto_b2b", pronto, 1);
        go(0, 16'd0, pick(20'h00000, 20'hFFFF0), 0, 1);
        wait_cycles(20);

        // Start ignored while busy (sampled at E5)
        go(0, 16'd777, pick(20'h00777, 20'hFF777), 0, 1);
        wait_cycles(4);
        inicio = 1'b1;
        valor  = 16'd42;
        wait_cycles(1);
        inicio = 1'b0;
        chk("ocupado_during_ignored", ocupado, 1);
        wait_cycles(20);

        go(0, 16'd7, pick(20'h00007, 20'hFFFF7), 0, 1);
        wait_cycles(20);
        go(0, 16'd10000, pick(20'h10000, 20'h10000), 0, 1);
        wait_cycles(20);

        go(1, 16'd12345, pick(20'h0FFFF, 20'h0FFFF), 1, 1);
        wait_cycles(20);
        go(1, 16'd9999, pick(20'h09999, 20'h09999), 0, 1);
        wait_cycles(20);

        // Reset at E8 of a conversion: result discarded, no pronto
        go(0, 16'd4321, 20'h0, 0, 0);
        wait_cycles(7);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        chk("midreset_ocupado", ocupado, 0);
        chk("midreset_pronto", pronto, 0);
        chk("midreset_bcd", bcd, pick(20'h00000, 20'hFFFF0));
        chk("midreset_estouro", estouro, 0);
        wait_cycles(25);

        go(0, 16'd55, pick(20'h00055, 20'hFFF55), 0, 1);
        wait_cycles(25);

        chk("queue0_drained", q0.size(), 0);
        chk("queue4_drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
